// File: rtl/runway_scheduler.sv
// Runway scheduler: emergency-aware request queue feeding a pool of runways,
// each held busy for a fixed occupancy time after every grant.
module runway_scheduler #(
  parameter  int NUM_RUNWAYS   = 2,
  parameter  int QUEUE_DEPTH   = 4,
  parameter  int ID_WIDTH      = 4,
  parameter  int OCCUPY_CYCLES = 16,
  localparam int RW            = (NUM_RUNWAYS > 1) ? $clog2(NUM_RUNWAYS) : 1,
  localparam int CW            = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ID_WIDTH-1:0]    req_id,
  input  logic                   req_emergency,
  output logic                   grant_valid,
  output logic [ID_WIDTH-1:0]    grant_id,
  output logic [RW-1:0]          grant_runway,
  output logic [NUM_RUNWAYS-1:0] runway_active,
  output logic [CW-1:0]          queue_count
);

  localparam int              OW       = (OCCUPY_CYCLES > 1) ? $clog2(OCCUPY_CYCLES) : 1;
  localparam logic [CW-1:0]   DEPTH    = CW'(QUEUE_DEPTH);
  localparam logic [OW-1:0]   OCC_LOAD = OW'(OCCUPY_CYCLES - 1);

  logic [ID_WIDTH-1:0]    q_id   [QUEUE_DEPTH];
  logic [ID_WIDTH-1:0]    pop_id [QUEUE_DEPTH];
  logic [ID_WIDTH-1:0]    nxt_id [QUEUE_DEPTH];
  logic [CW-1:0]          cnt, ecnt;
  logic [CW-1:0]          cnt_pop, ecnt_pop;
  logic [CW-1:0]          cnt_nxt, ecnt_nxt;
  logic [CW-1:0]          ins_pos;
  logic                   push, pop;
  logic                   free_any;
  logic [RW-1:0]          free_idx;
  logic [OW-1:0]          occ [NUM_RUNWAYS];
  logic [NUM_RUNWAYS-1:0] active;

  assign req_ready     = (cnt < DEPTH);
  assign queue_count   = cnt;
  assign runway_active = active;
  assign push          = req_valid && req_ready;
  assign pop           = (cnt != '0) && free_any;

  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int unsigned r = 0; r < NUM_RUNWAYS; r++) begin
      if (!free_any && !active[r]) begin
        free_any = 1'b1;
        free_idx = RW'(r);
      end
    end
  end

  // Emergencies occupy the head region, so the head is an emergency iff ecnt != 0.
  always_comb begin
    cnt_pop  = cnt;
    ecnt_pop = ecnt;
    for (int unsigned i = 0; i < QUEUE_DEPTH; i++) pop_id[i] = q_id[i];
    if (pop) begin
      for (int unsigned i = 0; i < QUEUE_DEPTH - 1; i++) pop_id[i] = q_id[i+1];
      pop_id[QUEUE_DEPTH-1] = '0;
      cnt_pop = cnt - CW'(1);
      if (ecnt != '0) ecnt_pop = ecnt - CW'(1);
    end
  end

  // Insertion works on the post-pop image, so a same-edge pop always takes the old head.
  always_comb begin
    ins_pos  = req_emergency ? ecnt_pop : cnt_pop;
    cnt_nxt  = cnt_pop;
    ecnt_nxt = ecnt_pop;
    for (int unsigned i = 0; i < QUEUE_DEPTH; i++) nxt_id[i] = pop_id[i];
    if (push) begin
      for (int unsigned i = 1; i < QUEUE_DEPTH; i++) begin
        if (CW'(i) > ins_pos) nxt_id[i] = pop_id[i-1];
      end
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        if (CW'(i) == ins_pos) nxt_id[i] = req_id;
      end
      cnt_nxt = cnt_pop + CW'(1);
      if (req_emergency) ecnt_nxt = ecnt_pop + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) q_id[i] <= '0;
      cnt  <= '0;
      ecnt <= '0;
    end else begin
      q_id <= nxt_id;
      cnt  <= cnt_nxt;
      ecnt <= ecnt_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      grant_valid  <= 1'b0;
      grant_id     <= '0;
      grant_runway <= '0;
    end else begin
      grant_valid <= pop;
      if (pop) begin
        grant_id     <= q_id[0];
        grant_runway <= free_idx;
      end
    end
  end

  // A runway clearing this edge is not seen as free until the next one.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      active <= '0;
      for (int unsigned r = 0; r < NUM_RUNWAYS; r++) occ[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < NUM_RUNWAYS; r++) begin
        if (pop && (free_idx == RW'(r))) begin
          active[r] <= 1'b1;
          occ[r]    <= OCC_LOAD;
        end else if (active[r]) begin
          if (occ[r] != '0) occ[r] <= occ[r] - OW'(1);
          else              active[r] <= 1'b0;
        end
      end
    end
  end

endmodule
